// File: rtl/regfile_2r1w_dump.sv
// MIPS register file: one write port and two registered read ports with write bypass.
// Register 0 reads as zero. A dump sequencer streams every register out, one per cycle.
module regfile_2r1w_dump #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  state_t           state_r, next_s;
  logic [AW-1:0]    ptr_r;
  logic [WIDTH-1:0] rv_a_s, rv_b_s, rv_d_s;
  logic             valid_s, done_s, busy_s;

  // Architectural read value: r0 is zero, a same-cycle write wins over storage.
  function automatic logic [WIDTH-1:0] read_val(
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] stored,
    input logic             w_en,
    input logic [AW-1:0]    w_addr,
    input logic [WIDTH-1:0] w_data
  );
    if (addr == {AW{1'b0}}) begin
      return {WIDTH{1'b0}};
    end else if (w_en && (w_addr == addr)) begin
      return w_data;
    end else begin
      return stored;
    end
  endfunction

  // Bypassed read values for both ports and the dump pointer.
  always_comb begin
    rv_a_s = read_val(raddr_a, mem_r[raddr_a], we, waddr, wdata);
    rv_b_s = read_val(raddr_b, mem_r[raddr_b], we, waddr, wdata);
    rv_d_s = read_val(ptr_r,   mem_r[ptr_r],   we, waddr, wdata);
  end

  // Register storage; writes to r0 are dropped.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (we && (waddr != {AW{1'b0}})) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports: data holds when no request is made.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdata_a  <= {WIDTH{1'b0}};
      rvalid_a <= 1'b0;
      rdata_b  <= {WIDTH{1'b0}};
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      rvalid_b <= re_b;
      if (re_a) rdata_a <= rv_a_s;
      if (re_b) rdata_b <= rv_b_s;
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // Dump FSM next state: RUN exits on the last index, not on pointer wrap.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    if (dump_start) next_s = RUN; else next_s = IDLE;
      RUN:     if (ptr_r == LAST_ADDR) next_s = DONE; else next_s = RUN;
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Dump FSM outputs, registered below so they trail the state by one cycle.
  always_comb begin
    valid_s = 1'b0;
    done_s  = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      IDLE:    begin valid_s = 1'b0; done_s = 1'b0; busy_s = 1'b0; end
      RUN:     begin valid_s = 1'b1; done_s = 1'b0; busy_s = 1'b1; end
      DONE:    begin valid_s = 1'b0; done_s = 1'b1; busy_s = 1'b1; end
      default: begin valid_s = 1'b0; done_s = 1'b0; busy_s = 1'b0; end
    endcase
  end

  // Dump pointer and registered dump outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_r      <= {AW{1'b0}};
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= {AW{1'b0}};
      dump_data  <= {WIDTH{1'b0}};
      dump_done  <= 1'b0;
    end else begin
      dump_busy  <= busy_s;
      dump_valid <= valid_s;
      dump_done  <= done_s;
      if ((state_r == IDLE) && dump_start) begin
        ptr_r <= {AW{1'b0}};
      end else if (state_r == RUN) begin
        ptr_r <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (valid_s) begin
        dump_addr <= ptr_r;
        dump_data <= rv_d_s;
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w_dump.sv
// Directed bench for regfile_2r1w_dump: reference model plus read scoreboard queues,
// with dump entries checked against the model as they stream out.
module tb_regfile_2r1w_dump;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re_a, re_b;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
  logic        dump_start, dump_busy, dump_valid, dump_done;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  logic [31:0] model [32];
  logic [31:0] qa[$], qb[$];
  logic [31:0] last_a, last_b;
  int          dexp;
  int          n_cmp = 0;
  int          n_err = 0;
  int          guard;

  regfile_2r1w_dump #(.WIDTH(32), .DEPTH(32), .AW(5)) dut (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrv(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    else if (we && waddr == a) return wdata;
    else return model[a];
  endfunction

  // One clock: predict from the driven inputs, advance, then compare.
  task automatic tick();
    logic [31:0] e;
    logic pa, pb;
    pa = re_a;
    pb = re_b;
    if (pa) qa.push_back(mrv(raddr_a));
    if (pb) qb.push_back(mrv(raddr_b));
    if (we && waddr != 5'd0) model[waddr] = wdata;
    @(posedge clk);
    #1;
    chk("rvalid_a", {31'd0, rvalid_a}, {31'd0, pa});
    chk("rvalid_b", {31'd0, rvalid_b}, {31'd0, pb});
    if (pa) begin e = qa.pop_front(); chk("rdata_a", rdata_a, e); last_a = e; end
    else chk("rdata_a_hold", rdata_a, last_a);
    if (pb) begin e = qb.pop_front(); chk("rdata_b", rdata_b, e); last_b = e; end
    else chk("rdata_b_hold", rdata_b, last_b);
    if (dump_valid) begin
      chk("dump_addr", {27'd0, dump_addr}, dexp);
      chk("dump_data", dump_data, model[dexp[4:0]]);
      dexp++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata_a"}, rdata_a, 32'h0);
    chk({tag, "_rvalid_a"}, {31'd0, rvalid_a}, 32'h0);
    chk({tag, "_rdata_b"}, rdata_b, 32'h0);
    chk({tag, "_rvalid_b"}, {31'd0, rvalid_b}, 32'h0);
    chk({tag, "_dump_busy"}, {31'd0, dump_busy}, 32'h0);
    chk({tag, "_dump_valid"}, {31'd0, dump_valid}, 32'h0);
    chk({tag, "_dump_addr"}, {27'd0, dump_addr}, 32'h0);
    chk({tag, "_dump_data"}, dump_data, 32'h0);
    chk({tag, "_dump_done"}, {31'd0, dump_done}, 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    qa.delete();
    qb.delete();
    last_a = 32'h0;
    last_b = 32'h0;
  endtask

  initial begin
    clr = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re_a = 1'b0; re_b = 1'b0; raddr_a = 5'd0; raddr_b = 5'd0; dump_start = 1'b0;
    dexp = 0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    clr = 1'b0;

    // Write then read next cycle.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; tick();
    we = 1'b0; re_a = 1'b1; raddr_a = 5'd5; tick();
    re_a = 1'b0; tick();

    // Same-cycle write/read bypass on port B, both ports on one register.
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; re_b = 1'b1; raddr_b = 5'd7; tick();
    we = 1'b0; re_a = 1'b1; raddr_a = 5'd7; raddr_b = 5'd7; tick();
    re_a = 1'b0; re_b = 1'b0; tick();

    // Writes to r0 are dropped.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; tick();
    we = 1'b0; re_a = 1'b1; raddr_a = 5'd0; re_b = 1'b1; raddr_b = 5'd0; tick();
    re_a = 1'b0; re_b = 1'b0;

    // Fill and dump the whole file.
    for (int n = 1; n < 32; n++) begin
      we = 1'b1; waddr = 5'(n); wdata = n * 32'h01010101; tick();
    end
    we = 1'b0;
    dexp = 0;
    dump_start = 1'b1; tick();
    dump_start = 1'b0;
    guard = 0;
    while (!dump_valid && guard < 4) begin tick(); guard++; end
    chk("dump_first_valid", {31'd0, dump_valid}, 32'h1);
    guard = 0;
    while (dump_valid && guard < 40) begin tick(); guard++; end
    chk("dump_count", dexp, 32);
    chk("dump_done_pulse", {31'd0, dump_done}, 32'h1);
    tick();
    chk("dump_done_clear", {31'd0, dump_done}, 32'h0);
    chk("dump_busy_clear", {31'd0, dump_busy}, 32'h0);

    // Start ignored during RUN; write to r20 while entry 10 is out.
    dexp = 0;
    dump_start = 1'b1; tick();
    dump_start = 1'b0;
    guard = 0;
    while (!(dump_valid && dump_addr == 5'd10) && guard < 20) begin tick(); guard++; end
    chk("dump_reach_10", {27'd0, dump_addr}, 32'd10);
    we = 1'b1; waddr = 5'd20; wdata = 32'hCAFEF00D; dump_start = 1'b1; tick();
    we = 1'b0; dump_start = 1'b0;
    guard = 0;
    while (dump_valid && guard < 40) begin tick(); guard++; end
    chk("dump2_count", dexp, 32);
    chk("dump2_done", {31'd0, dump_done}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_restart", {31'd0, dump_valid}, 32'h0);
    end

    // Reset at the 10th dump entry aborts the dump and clears storage.
    dexp = 0;
    dump_start = 1'b1; tick();
    dump_start = 1'b0;
    guard = 0;
    while (!(dump_valid && dump_addr == 5'd9) && guard < 20) begin tick(); guard++; end
    chk("dump_reach_9", {27'd0, dump_addr}, 32'd9);
    clr = 1'b1;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("no_done_after_clr", {31'd0, dump_done}, 32'h0);
      chk("no_valid_after_clr", {31'd0, dump_valid}, 32'h0);
    end
    for (int r = 0; r < 32; r++) begin
      re_a = 1'b1; raddr_a = 5'(r); re_b = 1'b1; raddr_b = 5'(31 - r); tick();
    end
    re_a = 1'b0; re_b = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
